// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: widths, opcode map,
// status flag bit positions and the operand-loader state encoding.
package alu_pkg;

   localparam int WIDTH   = 8;
   localparam int SEL_W   = 3;
   localparam int NUM_OPS = 6;

   localparam logic [SEL_W-1:0] OP_ADD = 3'd0;
   localparam logic [SEL_W-1:0] OP_SUB = 3'd1;
   localparam logic [SEL_W-1:0] OP_AND = 3'd2;
   localparam logic [SEL_W-1:0] OP_OR  = 3'd3;
   localparam logic [SEL_W-1:0] OP_XOR = 3'd4;
   localparam logic [SEL_W-1:0] OP_NOT = 3'd5;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_OUT  = 3'd4
   } state_e;

   function automatic logic op_legal(input logic [SEL_W-1:0] op);
      return (32'(op) < NUM_OPS);
   endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-stream input, ALU operand/result hookup and result output of the loader.
// slave is the loader's view; master is the surrounding datapath/source view.
interface alu_operand_loader_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_y;
   logic             alu_cout;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       out_flags;
   logic             out_valid;
   logic             out_ready;
   logic             err;
   logic             busy;

   modport slave (
      input  in_data, in_valid, alu_y, alu_cout, out_ready,
      output in_ready, alu_a, alu_b, alu_sel, out_data, out_flags, out_valid, err, busy
   );

   modport master (
      output in_data, in_valid, alu_y, alu_cout, out_ready,
      input  in_ready, alu_a, alu_b, alu_sel, out_data, out_flags, out_valid, err, busy
   );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,C,Z} status from an ALU result; shared with the writeback stage.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] y_i,
   input  logic         cout_i,
   output logic [2:0]   flags_o
);
   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_Z] = (y_i == '0);
      flags_o[FLAG_C] = cout_i;
      flags_o[FLAG_N] = y_i[W-1];
   end
endmodule

// File: rtl/alu_operand_loader.sv
// Sequencer in front of the ALU: loads A, B, opcode from a byte stream,
// gives the ALU one stable execute cycle, then holds the result until taken.
module alu_operand_loader
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   alu_operand_loader_if.slave bus
);
   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, out_data_q;
   logic [SEL_W-1:0] sel_q;
   logic [2:0]       flags_q, flags_d;
   logic             out_valid_q, err_q, busy_q, in_ready_q;
   logic             in_xfer, out_xfer;
   logic [SEL_W-1:0] op_in;

   assign in_xfer  = bus.in_valid && in_ready_q;
   assign out_xfer = out_valid_q && bus.out_ready;
   assign op_in    = bus.in_data[SEL_W-1:0];

   alu_flag_gen #(.W(WIDTH)) u_flags (
      .y_i    (bus.alu_y),
      .cout_i (bus.alu_cout),
      .flags_o(flags_d)
   );

   // in_ready is registered and therefore reads 0 for the cycle after reset,
   // so every output is 0 there; it rises on the first S_A cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_A;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         out_data_q  <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_A: begin
               in_ready_q <= 1'b1;
               if (in_xfer) begin
                  a_q     <= bus.in_data;
                  busy_q  <= 1'b1;
                  state_q <= S_B;
               end
            end
            S_B: if (in_xfer) begin
               b_q     <= bus.in_data;
               state_q <= S_OP;
            end
            S_OP: if (in_xfer) begin
               if (op_legal(op_in)) begin
                  sel_q      <= op_in;
                  in_ready_q <= 1'b0;
                  state_q    <= S_EXEC;
               end else begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_A;
               end
            end
            S_EXEC: begin
               out_data_q  <= bus.alu_y;
               flags_q     <= flags_d;
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: if (out_xfer) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_A;
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_A;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_sel   = sel_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = flags_q;
   assign bus.out_valid = out_valid_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboarded bench for alu_operand_loader with a behavioural ALU attached.
module tb_alu_operand_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_operand_loader_if ifc ();
   alu_operand_loader dut (.clk(clk), .rst(rst), .bus(ifc));

   // out_ready: 0 = held low, 1 = held high, 2 = random each cycle
   int   ordy_mode = 1;
   logic rnd_bit   = 1'b0;
   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end
   assign ifc.out_ready = (ordy_mode == 1) || (ordy_mode == 2 && rnd_bit);

   // the existing ALU slices
   always_comb begin
      {ifc.alu_cout, ifc.alu_y} = 9'd0;
      case (ifc.alu_sel)
         3'd0: {ifc.alu_cout, ifc.alu_y} = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
         3'd1: {ifc.alu_cout, ifc.alu_y} = {1'b0, ifc.alu_a} - {1'b0, ifc.alu_b};
         3'd2: ifc.alu_y = ifc.alu_a & ifc.alu_b;
         3'd3: ifc.alu_y = ifc.alu_a | ifc.alu_b;
         3'd4: ifc.alu_y = ifc.alu_a ^ ifc.alu_b;
         3'd5: ifc.alu_y = ~ifc.alu_a;
         default: ;
      endcase
   end

   int n_cmp = 0, n_bad = 0;
   int err_seen = 0, exp_err = 0, n_results = 0, exp_results = 0;
   logic [10:0] sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: {N,C,Z,y} from plain integer arithmetic on the operands
   function automatic logic [10:0] ref_res(input int a, input int b, input int op);
      int y, c;
      c = 0;
      case (op)
         0: begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
         1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
         2: y = a & b;
         3: y = a | b;
         4: y = a ^ b;
         default: y = 255 - a;
      endcase
      return {(y >= 128) ? 1'b1 : 1'b0, c[0], (y == 0) ? 1'b1 : 1'b0, 8'(y)};
   endfunction

   // called at posedge+1, returns at posedge+1 after the accepting edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int cnt;
      repeat (gap) begin @(posedge clk); #1; end
      ifc.in_data  = b;
      ifc.in_valid = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (ifc.in_ready) break;
         cnt++;
         if (cnt > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: byte %0h never accepted", b);
            break;
         end
      end
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap);
      send_byte(a, gap);
      send_byte(b, gap);
      send_byte(op, gap);
      if (int'(op[2:0]) < 6) begin
         sb.push_back(ref_res(int'(a), int'(b), int'(op[2:0])));
         exp_results++;
      end else exp_err++;
   endtask

   task automatic wait_valid(input string nm);
      int cnt = 0;
      while (!ifc.out_valid) begin
         @(negedge clk);
         cnt++;
         if (cnt > 50) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: out_valid timeout", nm);
            break;
         end
      end
   endtask

   // monitor: pop and compare on every output handshake
   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.err) err_seen++;
         if (ifc.out_valid && ifc.out_ready) begin
            n_results++;
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_result: got %0h expected none", ifc.out_data);
            end else begin
               logic [10:0] e;
               e = sb.pop_front();
               chk("result_data", 32'(ifc.out_data), 32'(e[7:0]));
               chk("result_flags", 32'(ifc.out_flags), 32'(e[10:8]));
            end
         end
      end
   end

   initial begin
      logic [7:0] held;
      int cnt;
      ifc.in_data  = '0;
      ifc.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {ifc.alu_a, ifc.alu_b, 5'(ifc.alu_sel), ifc.out_data, 3'(ifc.out_flags),
                            ifc.out_valid, ifc.err, ifc.busy, ifc.in_ready}, 32'd0);
      @(posedge clk); #1;

      // case 1: OR, immediate consumer, latency and busy
      ordy_mode = 1;
      send3(8'hAA, 8'hCC, 8'h03, 0);
      @(negedge clk);
      chk("exec_cycle_valid", 32'(ifc.out_valid), 32'd0);
      chk("exec_cycle_ready", 32'(ifc.in_ready), 32'd0);
      chk("exec_cycle_busy", 32'(ifc.busy), 32'd1);
      @(negedge clk);
      chk("out_valid_rise", 32'(ifc.out_valid), 32'd1);
      chk("case1_flags", 32'(ifc.out_flags), 32'b100);
      @(negedge clk);
      chk("out_valid_one_cycle", 32'(ifc.out_valid), 32'd0);
      chk("busy_returns", 32'(ifc.busy), 32'd0);
      @(posedge clk); #1;

      // case 2: zero result
      send3(8'h00, 8'h00, 8'h03, 0);
      wait_valid("case2");
      chk("case2_zero_flag", 32'(ifc.out_flags), 32'b001);
      @(posedge clk); #1;

      // case 3: backpressure holds the result
      ordy_mode = 0;
      send3(8'hEC, 8'h13, 8'h03, 0);
      wait_valid("case3");
      held = ifc.out_data;
      chk("case3_data", 32'(held), 32'hFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(ifc.out_valid), 32'd1);
         chk("hold_ready", 32'(ifc.in_ready), 32'd0);
         chk("hold_data", 32'(ifc.out_data), 32'(held));
      end
      @(posedge clk); #1 ordy_mode = 1;
      @(posedge clk);
      @(negedge clk);
      chk("release_valid", 32'(ifc.out_valid), 32'd0);
      chk("release_ready", 32'(ifc.in_ready), 32'd1);
      @(posedge clk); #1;

      // case 4: illegal opcode, then a good transaction
      send3(8'h12, 8'h34, 8'h07, 0);
      @(negedge clk);
      chk("err_pulse", 32'(ifc.err), 32'd1);
      chk("err_sel_kept", 32'(ifc.alu_sel), 32'd3);
      @(negedge clk);
      chk("err_one_cycle", 32'(ifc.err), 32'd0);
      chk("err_no_result", 32'(ifc.out_valid), 32'd0);
      @(posedge clk); #1;
      send3(8'hF0, 8'h0F, 8'h03, 0);
      wait_valid("case4");
      @(posedge clk); #1;

      // case 5: reset while waiting for B
      send_byte(8'h55, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midop_reset_outputs", {ifc.alu_a, ifc.alu_b, 5'(ifc.alu_sel), ifc.out_data, 3'(ifc.out_flags),
                                  ifc.out_valid, ifc.err, ifc.busy, ifc.in_ready}, 32'd0);
      @(posedge clk); #1;
      send3(8'h01, 8'h80, 8'h03, 0);
      wait_valid("case5");
      @(posedge clk); #1;

      // case 6: in_valid toggling
      send3(8'h0F, 8'hF0, 8'h03, 1);
      wait_valid("case6");
      @(posedge clk); #1;

      // random traffic, random backpressure and gaps
      ordy_mode = 2;
      for (int t = 0; t < 60; t++) begin
         logic [7:0] a, b, op;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         op = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) != 0) op[2:0] = 3'($urandom_range(0, 5));
         send3(a, b, op, int'($urandom_range(0, 2)));
      end

      ordy_mode = 1;
      cnt = 0;
      while (sb.size() != 0 && cnt < 100) begin @(negedge clk); cnt++; end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk("result_count", 32'(n_results), 32'(exp_results));
      chk("err_count", 32'(err_seen), 32'(exp_err));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
